// File: rtl/mdu_seq_if.sv
// mdu_seq_if: request/response bundle between the execute stage and the
// iterative multiply/divide unit.
//   start_i  request strobe (sampled by the unit only while idle)
//   op_i     RV32M funct3
//   a_i/b_i  rs1/rs2 operands
//   busy_o   unit occupied, core must stall
//   valid_o  one-cycle result strobe
//   result_o result, held until overwritten by the next completed op
interface mdu_seq_if;
  logic        start_i;
  logic [2:0]  op_i;
  logic [31:0] a_i;
  logic [31:0] b_i;
  logic        busy_o;
  logic        valid_o;
  logic [31:0] result_o;

  // Requester side (core / testbench)
  modport master (
    output start_i, op_i, a_i, b_i,
    input  busy_o, valid_o, result_o
  );

  // Unit side
  modport slave (
    input  start_i, op_i, a_i, b_i,
    output busy_o, valid_o, result_o
  );
endinterface

// File: rtl/mdu_seq.sv
// mdu_seq: iterative RV32M multiply/divide unit.
// Shift-add multiply and restoring divide, one bit per cycle, on unsigned
// magnitudes with a sign fix on the final iteration. Divide-by-zero and
// signed overflow complete in one cycle.
// Ports:
//   clk_i  clock, rising edge
//   rst_i  asynchronous active-high reset
//   bus    mdu_seq_if.slave (start_i/op_i/a_i/b_i in, busy_o/valid_o/result_o out)
module mdu_seq #(
  parameter int unsigned XLEN = 32,
  parameter int unsigned ITER = 32
) (
  input  logic      clk_i,
  input  logic      rst_i,
  mdu_seq_if.slave  bus
);

  localparam int unsigned CNT_W = $clog2(ITER);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(ITER - 1);

  localparam logic [2:0] OP_MUL    = 3'b000;
  localparam logic [2:0] OP_MULH   = 3'b001;
  localparam logic [2:0] OP_MULHSU = 3'b010;
  localparam logic [2:0] OP_MULHU  = 3'b011;
  localparam logic [2:0] OP_DIV    = 3'b100;
  localparam logic [2:0] OP_DIVU   = 3'b101;
  localparam logic [2:0] OP_REM    = 3'b110;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [XLEN-1:0]   hi_q, hi_d;     // product high half / partial remainder
  logic [XLEN-1:0]   lo_q, lo_d;     // multiplier / dividend, becomes product low / quotient
  logic [XLEN-1:0]   opnd_q, opnd_d; // multiplicand / divisor magnitude
  logic [2:0]        op_q, op_d;
  logic              neg_q, neg_d;         // negate product or quotient
  logic              neg_rem_q, neg_rem_d; // negate remainder (dividend sign)
  logic [XLEN-1:0]   result_q, result_d;
  logic              busy_q, busy_d;
  logic              valid_q, valid_d;

  // Operand decode and magnitudes for the request presented this cycle
  logic            is_div, a_signed, b_signed;
  logic            div_zero, div_ovf;
  logic [XLEN-1:0] a_mag, b_mag;

  always_comb begin
    is_div   = bus.op_i[2];
    a_signed = (bus.op_i == OP_MULH) || (bus.op_i == OP_MULHSU) ||
               (bus.op_i == OP_DIV)  || (bus.op_i == OP_REM);
    b_signed = (bus.op_i == OP_MULH) || (bus.op_i == OP_DIV) || (bus.op_i == OP_REM);
    a_mag    = (a_signed && bus.a_i[XLEN-1]) ? (~bus.a_i + XLEN'(1)) : bus.a_i;
    b_mag    = (b_signed && bus.b_i[XLEN-1]) ? (~bus.b_i + XLEN'(1)) : bus.b_i;
    div_zero = is_div && (bus.b_i == '0);
    // Only the signed ops (funct3[0]=0) can overflow
    div_ovf  = is_div && !bus.op_i[0] &&
               (bus.a_i == {1'b1, {(XLEN-1){1'b0}}}) && (bus.b_i == '1);
  end

  // One iteration of the shared datapath
  logic [XLEN:0]   mul_sum, div_shift, div_trial;
  logic [XLEN-1:0] hi_step, lo_step;

  always_comb begin
    mul_sum   = lo_q[0] ? ((XLEN+1)'(hi_q) + (XLEN+1)'(opnd_q)) : (XLEN+1)'(hi_q);
    div_shift = {hi_q, lo_q[XLEN-1]};
    div_trial = div_shift - {1'b0, opnd_q};
    if (op_q[2]) begin
      // Restoring divide: keep the subtraction only if it did not borrow
      if (!div_trial[XLEN]) begin
        hi_step = div_trial[XLEN-1:0];
        lo_step = {lo_q[XLEN-2:0], 1'b1};
      end else begin
        hi_step = div_shift[XLEN-1:0];
        lo_step = {lo_q[XLEN-2:0], 1'b0};
      end
    end else begin
      // Shift-add multiply: the carry lands in the top of the new high half
      hi_step = mul_sum[XLEN:1];
      lo_step = {mul_sum[0], lo_q[XLEN-1:1]};
    end
  end

  // Sign-fixed final result, computed from the last iteration's outputs
  logic [2*XLEN-1:0] prod, prod_fix;
  logic [XLEN-1:0]   quo_fix, rem_fix, final_res;

  always_comb begin
    prod     = {hi_step, lo_step};
    prod_fix = neg_q ? (~prod + (2*XLEN)'(1)) : prod;
    quo_fix  = neg_q ? (~lo_step + XLEN'(1)) : lo_step;
    rem_fix  = neg_rem_q ? (~hi_step + XLEN'(1)) : hi_step;
    case (op_q)
      OP_MUL:                       final_res = prod_fix[XLEN-1:0];
      OP_MULH, OP_MULHSU, OP_MULHU: final_res = prod_fix[2*XLEN-1:XLEN];
      OP_DIV, OP_DIVU:              final_res = quo_fix;
      default:                      final_res = rem_fix;
    endcase
  end

  // Next-state and register inputs
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    hi_d      = hi_q;
    lo_d      = lo_q;
    opnd_d    = opnd_q;
    op_d      = op_q;
    neg_d     = neg_q;
    neg_rem_d = neg_rem_q;
    result_d  = result_q;

    case (state_q)
      IDLE: begin
        if (bus.start_i) begin
          op_d  = bus.op_i;
          cnt_d = '0;
          if (div_zero) begin
            state_d  = DONE;
            result_d = bus.op_i[1] ? bus.a_i : '1;
          end else if (div_ovf) begin
            // a is 0x80000000 here, which is the DIV result
            state_d  = DONE;
            result_d = bus.op_i[1] ? '0 : bus.a_i;
          end else begin
            state_d   = CALC;
            hi_d      = '0;
            lo_d      = is_div ? a_mag : b_mag;
            opnd_d    = is_div ? b_mag : a_mag;
            neg_d     = (a_signed && bus.a_i[XLEN-1]) ^ (b_signed && bus.b_i[XLEN-1]);
            neg_rem_d = is_div && a_signed && bus.a_i[XLEN-1];
          end
        end
      end
      CALC: begin
        hi_d  = hi_step;
        lo_d  = lo_step;
        cnt_d = cnt_q + CNT_W'(1);
        if (cnt_q == CNT_LAST) begin
          state_d  = DONE;
          cnt_d    = '0;
          result_d = final_res;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase

    busy_d  = (state_d != IDLE);
    valid_d = (state_d == DONE);
  end

  // State and datapath registers
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      hi_q      <= '0;
      lo_q      <= '0;
      opnd_q    <= '0;
      op_q      <= '0;
      neg_q     <= 1'b0;
      neg_rem_q <= 1'b0;
      result_q  <= '0;
      busy_q    <= 1'b0;
      valid_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      hi_q      <= hi_d;
      lo_q      <= lo_d;
      opnd_q    <= opnd_d;
      op_q      <= op_d;
      neg_q     <= neg_d;
      neg_rem_q <= neg_rem_d;
      result_q  <= result_d;
      busy_q    <= busy_d;
      valid_q   <= valid_d;
    end
  end

  assign bus.busy_o   = busy_q;
  assign bus.valid_o  = valid_q;
  assign bus.result_o = result_q;

endmodule

// File: tb/tb_mdu_seq.sv
// tb_mdu_seq: directed vector bench for mdu_seq.
// Latency is counted as the number of rising edges from the accepting edge N
// to the edge that first samples valid_o high (33 normal, 1 fast path).
module tb_mdu_seq;

  localparam logic [2:0] OP_MUL    = 3'b000;
  localparam logic [2:0] OP_MULH   = 3'b001;
  localparam logic [2:0] OP_MULHSU = 3'b010;
  localparam logic [2:0] OP_MULHU  = 3'b011;
  localparam logic [2:0] OP_DIV    = 3'b100;
  localparam logic [2:0] OP_DIVU   = 3'b101;
  localparam logic [2:0] OP_REM    = 3'b110;
  localparam logic [2:0] OP_REMU   = 3'b111;

  localparam int NVEC = 21;

  typedef struct {
    string       name;
    logic [2:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] exp;
    int          lat;
  } vec_t;

  logic clk_i;
  logic rst_i;
  mdu_seq_if bus ();

  mdu_seq #(.XLEN(32), .ITER(32)) dut (
    .clk_i (clk_i),
    .rst_i (rst_i),
    .bus   (bus.slave)
  );

  int checks;
  int errors;
  vec_t vecs [NVEC];

  initial clk_i = 1'b0;
  always #5 clk_i = ~clk_i;

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic drive(input logic start, input logic [2:0] op,
                       input logic [31:0] a, input logic [31:0] b);
    bus.start_i = start;
    bus.op_i    = op;
    bus.a_i     = a;
    bus.b_i     = b;
  endtask

  // Called just after the accepting edge; counts edges until valid_o is seen
  task automatic wait_valid(input string name, output int lat);
    int k;
    k = 0;
    while (bus.valid_o !== 1'b1 && k < 40) begin
      tick();
      k++;
    end
    if (k >= 40) begin
      errors++;
      checks++;
      $display("FAIL %s_timeout: got no valid expected valid within 40 cycles", name);
    end
    lat = k + 1;
  endtask

  // Full transaction: accept, garble inputs, wait, check result/latency/pulse
  task automatic run_op(input string name, input logic [2:0] op, input logic [31:0] a,
                        input logic [31:0] b, input logic [31:0] exp, input int exp_lat);
    int lat;
    drive(1'b1, op, a, b);
    tick();
    drive(1'b0, ~op, ~a, b ^ 32'h5A5A_A5A5);
    check({name, "_busy"}, 32'(bus.busy_o), 32'd1);
    wait_valid(name, lat);
    check({name, "_lat"}, 32'(lat), 32'(exp_lat));
    check({name, "_res"}, bus.result_o, exp);
    tick();
    check({name, "_pulse"}, {30'd0, bus.valid_o, bus.busy_o}, 32'd0);
    check({name, "_hold"}, bus.result_o, exp);
  endtask

  initial begin
    int lat;
    checks = 0;
    errors = 0;

    vecs[0]  = '{"mul_m1",     OP_MUL,    32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000001, 33};
    vecs[1]  = '{"mulh_m1",    OP_MULH,   32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000000, 33};
    vecs[2]  = '{"mulhu_m1",   OP_MULHU,  32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 33};
    vecs[3]  = '{"mulhsu_m1",  OP_MULHSU, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF, 33};
    vecs[4]  = '{"div_m7_2",   OP_DIV,    32'hFFFFFFF9, 32'h00000002, 32'hFFFFFFFD, 33};
    vecs[5]  = '{"rem_m7_2",   OP_REM,    32'hFFFFFFF9, 32'h00000002, 32'hFFFFFFFF, 33};
    vecs[6]  = '{"divu_m7_2",  OP_DIVU,   32'hFFFFFFF9, 32'h00000002, 32'h7FFFFFFC, 33};
    vecs[7]  = '{"remu_m7_2",  OP_REMU,   32'hFFFFFFF9, 32'h00000002, 32'h00000001, 33};
    vecs[8]  = '{"div_z",      OP_DIV,    32'h12345678, 32'h00000000, 32'hFFFFFFFF, 1};
    vecs[9]  = '{"divu_z",     OP_DIVU,   32'h12345678, 32'h00000000, 32'hFFFFFFFF, 1};
    vecs[10] = '{"rem_z",      OP_REM,    32'h12345678, 32'h00000000, 32'h12345678, 1};
    vecs[11] = '{"remu_z",     OP_REMU,   32'h12345678, 32'h00000000, 32'h12345678, 1};
    vecs[12] = '{"div_ovf",    OP_DIV,    32'h80000000, 32'hFFFFFFFF, 32'h80000000, 1};
    vecs[13] = '{"rem_ovf",    OP_REM,    32'h80000000, 32'hFFFFFFFF, 32'h00000000, 1};
    vecs[14] = '{"divu_ovf",   OP_DIVU,   32'h80000000, 32'hFFFFFFFF, 32'h00000000, 33};
    vecs[15] = '{"remu_ovf",   OP_REMU,   32'h80000000, 32'hFFFFFFFF, 32'h80000000, 33};
    vecs[16] = '{"mul_zero",   OP_MUL,    32'h00000000, 32'h00000005, 32'h00000000, 33};
    vecs[17] = '{"mulh_min",   OP_MULH,   32'h80000000, 32'h80000000, 32'h40000000, 33};
    vecs[18] = '{"mul_big",    OP_MUL,    32'h0001_0001, 32'h0000_FFFF, 32'hFFFF_FFFF, 33};
    vecs[19] = '{"div_100_m7", OP_DIV,    32'd100,      32'hFFFFFFF9, 32'hFFFFFFF2, 33};
    vecs[20] = '{"rem_100_m7", OP_REM,    32'd100,      32'hFFFFFFF9, 32'h00000002, 33};

    // Power-on reset
    rst_i = 1'b1;
    drive(1'b0, OP_MUL, '0, '0);
    repeat (3) tick();
    check("reset_busy",   32'(bus.busy_o),  32'd0);
    check("reset_valid",  32'(bus.valid_o), 32'd0);
    check("reset_result", bus.result_o,     32'd0);
    rst_i = 1'b0;
    tick();
    check("idle_busy", 32'(bus.busy_o), 32'd0);

    // Vector table
    for (int i = 0; i < NVEC; i++)
      run_op(vecs[i].name, vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].exp, vecs[i].lat);

    // Async reset in the middle of a MULHU at counter 10
    drive(1'b1, OP_MULHU, 32'hFFFFFFFF, 32'hFFFFFFFF);
    tick();
    drive(1'b0, OP_MUL, '0, '0);
    repeat (10) tick();
    check("midrst_busy_pre", 32'(bus.busy_o), 32'd1);
    rst_i = 1'b1;
    #1;
    check("midrst_busy",   32'(bus.busy_o),  32'd0);
    check("midrst_valid",  32'(bus.valid_o), 32'd0);
    check("midrst_result", bus.result_o,     32'd0);
    tick();
    rst_i = 1'b0;
    tick();
    check("midrst_quiet", {30'd0, bus.valid_o, bus.busy_o}, 32'd0);
    run_op("mul_7_6", OP_MUL, 32'd7, 32'd6, 32'd42, 33);

    // Starts during CALC (counters 5 and 31) and DONE are ignored
    drive(1'b1, OP_DIVU, 32'd100, 32'd7);
    tick();                                   // edge N, counter 0
    drive(1'b0, OP_MUL, '0, '0);
    repeat (5) tick();                        // counter 5
    drive(1'b1, OP_MUL, 32'd3, 32'd3);
    tick();
    drive(1'b0, OP_MUL, '0, '0);
    check("hs_c5_valid", 32'(bus.valid_o), 32'd0);
    repeat (25) tick();                       // counter 31
    drive(1'b1, OP_REMU, 32'd9, 32'd4);
    tick();                                   // DONE
    drive(1'b0, OP_MUL, '0, '0);
    check("hs_done_valid", 32'(bus.valid_o), 32'd1);
    check("hs_done_res",   bus.result_o,     32'd14);
    drive(1'b1, OP_MULHU, 32'd1, 32'd1);
    tick();                                   // back to IDLE, start ignored
    drive(1'b0, OP_MUL, '0, '0);
    check("hs_idle", {30'd0, bus.valid_o, bus.busy_o}, 32'd0);
    check("hs_idle_res", bus.result_o, 32'd14);
    drive(1'b1, OP_MUL, 32'd3, 32'd5);
    tick();                                   // accepted the cycle after DONE
    drive(1'b0, OP_DIV, '1, '1);
    check("hs_accept_busy", 32'(bus.busy_o), 32'd1);
    repeat (6) tick();
    check("hs_hold_res", bus.result_o, 32'd14);
    wait_valid("hs_mul", lat);
    check("hs_mul_lat", 32'(lat), 32'd27);    // 6 ticks already consumed
    check("hs_mul_res", bus.result_o, 32'd15);
    tick();

    // start_i held high on the fast path: one op every two cycles
    drive(1'b1, OP_DIVU, 32'd5, 32'd0);
    tick();
    check("held_v1",   32'(bus.valid_o), 32'd1);
    check("held_r1",   bus.result_o,     32'hFFFFFFFF);
    drive(1'b1, OP_REMU, 32'd5, 32'd0);
    tick();
    check("held_gap", {30'd0, bus.valid_o, bus.busy_o}, 32'd0);
    tick();
    check("held_v2",   {30'd0, bus.valid_o, bus.busy_o}, 32'd3);
    check("held_r2",   bus.result_o, 32'd5);
    drive(1'b0, OP_MUL, '0, '0);
    tick();
    check("held_end", {30'd0, bus.valid_o, bus.busy_o}, 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/mdu_seq.md
Name: mdu_seq

Overview:
- Iterative RV32M multiply/divide unit. It sits beside the single-cycle ALU in the execute stage and takes the operations the ALU cannot complete in one cycle.
- Takes two 32-bit operands and a 3-bit M-extension funct3 code. Returns one 32-bit result after a fixed multi-cycle latency.
- Uses a start/busy/valid handshake so the core stalls while the unit is busy.

Parameters:
- XLEN, 32, operand/result width; only 32 is supported.
- ITER, 32, iteration count of the shift-add / restoring-divide loop; must equal XLEN.

Ports:
- clk_i  in  1  clock; all state updates on the rising edge.
- rst_i  in  1  asynchronous, active-high reset.
- start_i  in  1  request strobe; sampled only in IDLE.
- op_i  in  3  funct3: 000 MUL, 001 MULH, 010 MULHSU, 011 MULHU, 100 DIV, 101 DIVU, 110 REM, 111 REMU.
- a_i  in  32  rs1 operand; captured on accepted start.
- b_i  in  32  rs2 operand; captured on accepted start.
- busy_o  out  1  high whenever state != IDLE.
- valid_o  out  1  one-cycle pulse; result_o is valid in that cycle.
- result_o  out  32  result; holds its value until the next accepted start.

Behaviour:
- States: IDLE, CALC, DONE.
- Reset (async, any state, including mid-CALC):
  - state=IDLE.
  - busy_o=0, valid_o=0, result_o=0.
  - Iteration counter=0 and all internal registers=0.
  - No partial result is ever emitted.
- Accept:
  - In IDLE, start_i=1 at edge N captures op_i, a_i, b_i.
  - start_i while busy_o=1 is ignored; no queueing.
  - Input changes after the accepting edge have no effect.
- Sign handling:
  - Signed operands (MULH: a,b; MULHSU: a only; DIV/REM: a,b) are converted to magnitudes at capture.
  - The core loop is unsigned.
  - Final sign fix:
    - product negated if exactly one signed operand was negative;
    - quotient negated if the dividend and divisor signs differ;
    - remainder takes the dividend's sign.
- Multiply:
  - Shift-add, one multiplier bit per CALC cycle, 64-bit accumulator.
  - MUL returns product[31:0]; MULH/MULHSU/MULHU return product[63:32].
- Divide:
  - Restoring, one quotient bit per CALC cycle, 32-bit partial remainder plus one guard bit.
  - DIV/DIVU return the quotient; REM/REMU return the remainder.
- Normal timing:
  - IDLE -> CALC at edge N.
  - CALC lasts exactly ITER cycles; the counter goes 0..31.
  - CALC -> DONE after the edge where counter=31; sign fix is applied on that same edge.
  - In DONE: valid_o=1 and result_o updated, i.e. valid at edge N+33.
  - DONE -> IDLE on the next edge unconditionally.
  - busy_o is high from edge N through the DONE cycle.
  - A new start is acceptable in the cycle after DONE.
- Fast path (IDLE -> DONE directly, valid at edge N+1):
  - Divide by zero (b=0, ops 100-111): DIV/DIVU return 0xFFFFFFFF; REM/REMU return a.
  - Signed overflow (a=0x80000000, b=0xFFFFFFFF, DIV/REM): DIV returns 0x80000000; REM returns 0.
  - Multiply never takes the fast path, even with a zero operand.
- Boundary cases:
  - start_i held high continuously: a new operation is accepted each time the unit returns to IDLE. Back-to-back throughput is one op per 34 cycles (normal) or 2 cycles (fast path).
  - The DONE cycle never overlaps with accepting a new start.

Test Plan:
- Reset mid-op: MULHU a=0xFFFFFFFF b=0xFFFFFFFF; assert rst_i at CALC counter=10 -> busy_o, valid_o, result_o all 0 immediately (async). A following MUL 7*6 returns 42 at start+33.
- Multiply variants, a=0xFFFFFFFF b=0xFFFFFFFF:
  - MUL -> 0x00000001
  - MULH -> 0x00000000
  - MULHU -> 0xFFFFFFFE
  - MULHSU -> 0xFFFFFFFF
  - each with valid_o exactly one cycle at start+33.
- Signed divide a=0xFFFFFFF9 (-7), b=2:
  - DIV -> 0xFFFFFFFD (-3)
  - REM -> 0xFFFFFFFF (-1)
  - DIVU -> 0x7FFFFFFC
  - REMU -> 1
- Divide by zero, a=0x12345678 b=0: DIV and DIVU -> 0xFFFFFFFF; REM and REMU -> 0x12345678; valid_o at start+1.
- Overflow, a=0x80000000 b=0xFFFFFFFF: DIV -> 0x80000000, REM -> 0, valid at start+1. DIVU with the same operands -> 0x00000000 at start+33.
- Handshake: pulse start_i with new operands at CALC counters 5 and 31 and in the DONE cycle -> all ignored; result_o reflects only the first op; result_o stable until the next accepted start; new start accepted the cycle after DONE.
